// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with IF/ID register, stall hold buffer and redirect squash.
module fetch_unit #(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_SQUASH} state_t;
    state_t          r_state, w_next;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     r_hold;
    logic            w_load_rsp, w_load_hold, w_load, w_to_hold;
    logic [31:0]     w_instr;
    logic            w_unused;

    assign w_unused       = ^{BrPC[31:PC_W], BrPC[1:0]};
    assign imem_req_valid = r_state == S_REQ && !reset;
    assign imem_addr      = pc_q;

    always_comb begin
        w_load_rsp  = r_state == S_WAIT && imem_rsp_valid && (!if_valid || !stall);
        w_to_hold   = r_state == S_WAIT && imem_rsp_valid && if_valid && stall;
        w_load_hold = r_state == S_HOLD && !stall;
        w_load      = !PcSel && (w_load_rsp || w_load_hold);
        w_instr     = w_load_hold ? r_hold : imem_rsp_data;
        w_next      = r_state;
        // a redirect in WAIT/SQUASH still retires the in-flight response when it lands this cycle
        case (r_state)
            S_REQ:   w_next = imem_req_ready ? (PcSel ? S_SQUASH : S_WAIT) : S_REQ;
            S_WAIT:  w_next = imem_rsp_valid ? ((PcSel || !w_to_hold) ? S_REQ : S_HOLD)
                                             : (PcSel ? S_SQUASH : S_WAIT);
            S_HOLD:  w_next = (PcSel || !stall) ? S_REQ : S_HOLD;
            default: w_next = imem_rsp_valid ? S_REQ : S_SQUASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            pc_q     <= '0;
            r_hold   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= 32'h0000_0013;
        end else begin
            r_state  <= w_next;
            pc_q     <= PcSel ? {BrPC[PC_W-1:2], 2'b00} : (w_load ? pc_q + PC_W'(4) : pc_q);
            if_valid <= w_load || (!PcSel && if_valid && stall);
            if (!PcSel && w_to_hold)
                r_hold <= imem_rsp_data;
            if (w_load) begin
                if_pc    <= pc_q;
                if_instr <= w_instr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table for the basic fetch/stall walk plus scoreboarded redirect, wrap and reset sequences.
module tb_fetch_unit;
    logic        clk, reset, PcSel, stall, imem_req_valid, imem_req_ready, imem_rsp_valid, if_valid;
    logic [31:0] BrPC, imem_rsp_data, if_instr;
    logic [8:0]  imem_addr, if_pc;

    fetch_unit #(.PC_W(9)) dut (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    typedef struct {
        logic        stall, rdy, rsp;
        logic [31:0] data;
        logic        rv;
        logic [8:0]  addr;
        logic        iv;
        logic [8:0]  ipc;
        logic [31:0] ins;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    int          vecs = 0, errs = 0, pops = 0, lat = 1, cnt = 0;
    bit          sb_on = 0, pend = 0;
    logic [8:0]  pa;
    logic [40:0] sb[$];
    logic        pre_iv, pre_st;
    vec_t        vt[14];

    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // each newly loaded IF/ID instruction must match the next scoreboard entry
    always @(posedge clk) begin
        pre_iv = if_valid;
        pre_st = stall;
        @(negedge clk);
        if (sb_on && if_valid && !(pre_iv && pre_st)) begin
            check("ifid_sb", 64'({if_pc, if_instr}), 64'(sb.size() != 0 ? sb.pop_front() : '1));
            pops++;
        end
    end

    task automatic apply(input vec_t v);
        stall = v.stall; imem_req_ready = v.rdy; imem_rsp_valid = v.rsp; imem_rsp_data = v.data;
        #1;
        check("req", 64'({imem_req_valid, imem_addr}), 64'({v.rv, v.addr}));
        @(posedge clk); #1;
        check("ifid", 64'({if_valid, if_pc, if_instr}), 64'({v.iv, v.ipc, v.ins}));
    endtask

    task automatic step();
        logic acc;
        logic [8:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a = imem_addr;
        @(posedge clk); #1;
        imem_rsp_valid = 0;
        if (acc) begin pend = 1; pa = a; cnt = lat; end
        if (pend) begin
            if (cnt == 1) begin
                imem_rsp_valid = 1; imem_rsp_data = word(pa); pend = 0;
            end else cnt--;
        end
    endtask

    task automatic do_reset();
        reset = 1; PcSel = 0; BrPC = 0; stall = 0; imem_req_ready = 0; imem_rsp_valid = 0; pend = 0;
        step(); step();
        reset = 0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pops < n && k < 20) begin step(); k++; end
        check("pop_cnt", 64'(pops), 64'(n));
    endtask

    initial begin
        vt[0]  = '{0, 1, 0, 0,             1, 9'h000, 0, 9'h000, NOP};
        vt[1]  = '{0, 0, 1, word(9'h000),  0, 9'h000, 1, 9'h000, word(9'h000)};
        vt[2]  = '{0, 1, 0, 0,             1, 9'h004, 0, 9'h000, word(9'h000)};
        vt[3]  = '{0, 0, 1, word(9'h004),  0, 9'h004, 1, 9'h004, word(9'h004)};
        vt[4]  = '{0, 1, 0, 0,             1, 9'h008, 0, 9'h004, word(9'h004)};
        vt[5]  = '{0, 0, 1, word(9'h008),  0, 9'h008, 1, 9'h008, word(9'h008)};
        vt[6]  = '{1, 1, 0, 0,             1, 9'h00C, 1, 9'h008, word(9'h008)};
        vt[7]  = '{1, 0, 1, word(9'h00C),  0, 9'h00C, 1, 9'h008, word(9'h008)};
        vt[8]  = '{1, 0, 0, 0,             0, 9'h00C, 1, 9'h008, word(9'h008)};
        vt[9]  = '{0, 0, 0, 0,             0, 9'h00C, 1, 9'h00C, word(9'h00C)};
        vt[10] = '{0, 0, 1, 32'hDEAD_BEEF, 1, 9'h010, 0, 9'h00C, word(9'h00C)};
        vt[11] = '{0, 1, 0, 0,             1, 9'h010, 0, 9'h00C, word(9'h00C)};
        vt[12] = '{0, 0, 1, word(9'h010),  0, 9'h010, 1, 9'h010, word(9'h010)};
        vt[13] = '{1, 1, 0, 0,             1, 9'h014, 1, 9'h010, word(9'h010)};

        reset = 1; PcSel = 0; BrPC = 0; stall = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst_ifid", 64'({if_valid, if_pc, if_instr}), 64'({1'b0, 9'h000, NOP}));
        reset = 0;
        #1;
        check("rst_release_req", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 9'h000}));
        for (int i = 0; i < 14; i++) apply(vt[i]);

        sb_on = 1;
        // redirect while waiting on a slow response
        do_reset(); lat = 3; imem_req_ready = 1;
        step();
        PcSel = 1; BrPC = 32'hFFFF_FE43;
        step();
        PcSel = 0;
        check("redir_flush", 64'({if_valid, imem_req_valid}), 64'(0));
        begin
            int k = 0;
            while (!imem_req_valid && k < 8) begin step(); k++; end
        end
        check("redir_addr", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 9'h040}));
        sb.push_back({9'h040, word(9'h040)});
        wait_pops(pops + 1);

        // redirect together with stall: flush wins
        do_reset(); lat = 1; imem_req_ready = 1; stall = 1;
        sb.push_back({9'h000, word(9'h000)});
        step(); step();
        check("stall_hold_valid", 64'({if_valid, if_pc}), 64'({1'b1, 9'h000}));
        PcSel = 1; BrPC = 32'h0000_0040;
        step();
        PcSel = 0;
        check("sel_stall_flush", 64'({if_valid, imem_req_valid}), 64'(0));
        step();
        check("sel_stall_target", 64'({if_valid, imem_req_valid, imem_addr}), 64'({1'b0, 1'b1, 9'h040}));
        stall = 0;
        sb.push_back({9'h040, word(9'h040)});
        wait_pops(pops + 1);

        // PC wrap from 0x1FC
        do_reset(); lat = 1;
        PcSel = 1; BrPC = 32'h0000_01FC;
        step();
        PcSel = 0;
        check("wrap_start", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 9'h1FC}));
        imem_req_ready = 1;
        sb.push_back({9'h1FC, word(9'h1FC)});
        sb.push_back({9'h000, word(9'h000)});
        sb.push_back({9'h004, word(9'h004)});
        wait_pops(pops + 3);

        // reset in WAIT abandons the in-flight response
        do_reset(); lat = 4; imem_req_ready = 1;
        step(); step();
        reset = 1;
        step();
        check("rst_wait", 64'({imem_req_valid, if_valid, if_pc, if_instr}), 64'({2'b00, 9'h000, NOP}));
        reset = 0; imem_req_ready = 0;
        step(); step();
        check("late_rsp_ignored", 64'({if_valid, imem_req_valid, imem_addr}), 64'({1'b0, 1'b1, 9'h000}));
        imem_req_ready = 1;
        sb.push_back({9'h000, word(9'h000)});
        wait_pops(pops + 1);
        step();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one parameter: PC_W, default 9, the width of the byte-address PC.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 PcSel  in  1  redirect request from the branch unit; 1 = take BrPC.
REQ-005 BrPC  in  32  redirect target; bits [PC_W-1:2] used, bits [1:0] and [31:PC_W] ignored.
REQ-006 stall  in  1  decode stall from the hazard unit; holds the IF/ID register.
REQ-007 imem_req_valid  out  1  instruction fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-009 imem_addr  out  PC_W  fetch address, always 4-byte aligned.
REQ-010 imem_rsp_valid  in  1  instruction data valid; at most one outstanding request.
REQ-011 imem_rsp_data  in  32  fetched instruction.
REQ-012 if_valid  out  1  IF/ID register holds a live instruction.
REQ-013 if_pc  out  PC_W  PC of the IF/ID instruction; feeds Cur_PC of the branch unit.
REQ-014 if_instr  out  32  instruction in IF/ID.

Function
REQ-015 State SHALL be held in pc_q[PC_W-1:0] with bits [1:0] always 0, and in an FSM with states REQ, WAIT, HOLD, SQUASH.
REQ-016 In REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal pc_q; on imem_req_ready the FSM SHALL go to WAIT; in all other states imem_req_valid SHALL be 0.
REQ-017 In WAIT, on imem_rsp_valid with (!if_valid || !stall), the response SHALL load IF/ID (if_valid=1, if_pc=pc_q, if_instr=data), pc_q SHALL become pc_q+4 modulo 2^PC_W, and the FSM SHALL go to REQ.
REQ-018 In WAIT, on imem_rsp_valid with if_valid && stall, the data SHALL be captured into a one-entry hold buffer and the FSM SHALL go to HOLD.
REQ-019 In HOLD, on the first cycle with stall=0, the buffer SHALL load IF/ID, pc_q SHALL advance by 4, and the FSM SHALL go to REQ.
REQ-020 In SQUASH, the next imem_rsp_valid SHALL be discarded without touching IF/ID or pc_q, and the FSM SHALL then go to REQ.
REQ-021 While if_valid && stall and no redirect, if_valid, if_pc and if_instr SHALL hold their values.
REQ-022 While !stall and no new instruction is loaded, if_valid SHALL clear next cycle (the bubble advances to ID).
REQ-023 PcSel=1 SHALL take priority over stall and response events: pc_q <= {BrPC[PC_W-1:2],2'b00} and if_valid <= 0 (flush) next cycle.
REQ-024 On PcSel=1, next state SHALL be: from WAIT -> SQUASH, or REQ if imem_rsp_valid is in the same cycle (response dropped); from HOLD -> REQ (buffer dropped); from REQ with imem_req_ready -> SQUASH; from REQ without ready -> REQ; from SQUASH -> SQUASH, or REQ if the squashed response arrives the same cycle.
REQ-025 imem_rsp_valid in state REQ SHALL be ignored.
REQ-026 PC increment SHALL wrap from 2^PC_W-4 to 0 with no error indication.
REQ-027 Fetch latency SHALL be 1 cycle from request acceptance plus memory latency to if_valid; sustained throughput is one instruction per 2 cycles with single-cycle memory.

Reset
REQ-028 With reset=1 at a clock edge: pc_q=0, FSM=REQ, hold buffer empty, if_valid=0, if_pc=0, if_instr=32'h00000013 (NOP).
REQ-029 imem_req_valid SHALL be 0 while reset is asserted; reset SHALL override PcSel, stall and any in-flight transaction, which is abandoned.

Verification
REQ-030 Reset release, ready=1, 1-cycle memory: addresses 0x000, 0x004, 0x008 requested; if_pc follows 0,4,8 with matching if_instr.
REQ-031 stall=1 with if_valid=1 when a response arrives: FSM to HOLD, if_instr unchanged; stall drops -> buffered word appears in IF/ID next cycle, next request at pc+4.
REQ-032 PcSel=1, BrPC=0x40 while in WAIT: if_valid=0 next cycle, the pending response is discarded, next request at 0x040, if_pc=0x040 after it returns.
REQ-033 PcSel=1 with stall=1 simultaneously: flush wins, if_valid=0, pc_q=0x040 target.
REQ-034 pc_q=0x1FC (PC_W=9), response accepted: next request at 0x000.
REQ-035 reset asserted in WAIT: next cycle pc_q=0, state REQ, if_instr=0x00000013, a late imem_rsp_valid is ignored.
